// File: rtl/ps2_mouse_pkg.sv
// Shared constants and state encoding for the PS/2 mouse bring-up logic.
package ps2_mouse_pkg;

   // Host-to-mouse commands
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] CMD_SET_RES  = 8'hE8;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;

   // Mouse-to-host responses
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_ID       = 8'h00;

   // Command list runs over steps 0..LAST_STEP
   typedef logic [2:0] step_t;
   localparam step_t LAST_STEP = 3'd5;

   // State encoding
   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      StIdle    = 4'd0,
      StSend    = 4'd1,
      StWaitTx  = 4'd2,
      StWaitAck = 4'd3,
      StWaitBat = 4'd4,
      StWaitId  = 4'd5,
      StNext    = 4'd6,
      StDone    = 4'd7,
      StError   = 4'd8
   } state_e;

endpackage

// File: rtl/ps2_watchdog_timer.sv
// Loadable down-counter; expired is high while enabled and the count sits at zero.
module ps2_watchdog_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // Load has priority; otherwise count down while enabled, saturating at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign expired = en && (count == '0);

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// Drives the PS/2 mouse through reset, rate/resolution setup and stream enable,
// checking every response with a timeout and a bounded retry budget.
module ps2_mouse_init_sequencer
   import ps2_mouse_pkg::*;
#(
   parameter logic [7:0]  SAMPLE_RATE = 8'd100,
   parameter logic [7:0]  RESOLUTION  = 8'd2,
   parameter int unsigned ACK_TIMEOUT = 100_000,
   parameter int unsigned BAT_TIMEOUT = 50_000_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] rx_data,
   input  logic       rx_done_tick,
   input  logic       tx_done_tick,
   output logic       wr_ps2,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       init_done,
   output logic       init_error,
   output logic [3:0] retry_cnt
);

   localparam int unsigned TMR_MAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

   state_e           state;
   step_t            step;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_en;
   logic             expired;
   logic             resend;
   logic             bad_rsp;
   logic             timed_out;
   logic             do_restart;

   function automatic logic [7:0] cmd_of(input step_t s);
      logic [7:0] c;
      case (s)
         3'd0:    c = CMD_RESET;
         3'd1:    c = CMD_SET_RATE;
         3'd2:    c = SAMPLE_RATE;
         3'd3:    c = CMD_SET_RES;
         3'd4:    c = RESOLUTION;
         default: c = CMD_ENABLE;
      endcase
      return c;
   endfunction

   ps2_watchdog_timer #(
      .WIDTH(TMR_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .load_val(tmr_val),
      .en      (tmr_en),
      .expired (expired)
   );

   assign tmr_en = state inside {StWaitTx, StWaitAck, StWaitBat, StWaitId};

   // Timer reloads on entry to each wait state; only the reset ACK arms the long BAT wait
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TMR_W'(ACK_TIMEOUT);
      case (state)
         StSend:    tmr_load = 1'b1;
         StWaitTx:  tmr_load = tx_done_tick;
         StWaitAck: begin
            if (rx_done_tick && (rx_data == RSP_ACK) && (step == '0)) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(BAT_TIMEOUT);
            end
         end
         StWaitBat: tmr_load = rx_done_tick && (rx_data == RSP_BAT_OK);
         default:   tmr_load = 1'b0;
      endcase
   end

   // Classify failures; a tick arriving on the expiry cycle beats the timeout
   always_comb begin
      resend    = 1'b0;
      bad_rsp   = 1'b0;
      timed_out = 1'b0;
      case (state)
         StWaitTx:  timed_out = !tx_done_tick && expired;
         StWaitAck: begin
            if (rx_done_tick) begin
               resend  = (rx_data == RSP_RESEND);
               bad_rsp = (rx_data != RSP_ACK) && (rx_data != RSP_RESEND);
            end else begin
               timed_out = expired;
            end
         end
         StWaitBat: begin
            if (rx_done_tick) bad_rsp = (rx_data != RSP_BAT_OK);
            else              timed_out = expired;
         end
         StWaitId: begin
            if (rx_done_tick) bad_rsp = (rx_data != RSP_ID);
            else              timed_out = expired;
         end
         default: ;
      endcase
   end

   assign do_restart = bad_rsp || timed_out;

   // Main sequencer; wr_ps2/tx_data are registered on every transition into SEND
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         step      <= '0;
         retry_cnt <= '0;
         wr_ps2    <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         wr_ps2 <= 1'b0;
         if (resend || do_restart) begin
            if (retry_cnt == RETRY_LIMIT) begin
               state <= StError;
            end else begin
               retry_cnt <= retry_cnt + 4'd1;
               step      <= resend ? step : '0;
               tx_data   <= cmd_of(resend ? step : '0);
               wr_ps2    <= 1'b1;
               state     <= StSend;
            end
         end else begin
            case (state)
               StIdle, StDone, StError: begin
                  if (start) begin
                     step      <= '0;
                     retry_cnt <= '0;
                     tx_data   <= cmd_of('0);
                     wr_ps2    <= 1'b1;
                     state     <= StSend;
                  end
               end
               StSend:    state <= StWaitTx;
               StWaitTx:  if (tx_done_tick) state <= StWaitAck;
               // Only an ACK gets this far; other bytes were handled above
               StWaitAck: if (rx_done_tick) state <= (step == '0) ? StWaitBat : StNext;
               StWaitBat: if (rx_done_tick) state <= StWaitId;
               StWaitId:  if (rx_done_tick) state <= StNext;
               StNext: begin
                  if (step == LAST_STEP) begin
                     state <= StDone;
                  end else begin
                     step    <= step + 3'd1;
                     tx_data <= cmd_of(step + 3'd1);
                     wr_ps2  <= 1'b1;
                     state   <= StSend;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   assign busy       = !(state inside {StIdle, StDone, StError});
   assign init_done  = (state == StDone);
   assign init_error = (state == StError);

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Scoreboarded bench: expected transmit bytes are queued as stimulus is applied and
// checked whenever the sequencer raises wr_ps2.
module tb_ps2_mouse_init_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       tx_done_tick;
   logic       wr_ps2;
   logic [7:0] tx_data;
   logic       busy;
   logic       init_done;
   logic       init_error;
   logic [3:0] retry_cnt;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_cmd [6];

   always #5 clk = ~clk;

   ps2_mouse_init_sequencer #(
      .SAMPLE_RATE(8'd100),
      .RESOLUTION (8'd2),
      .ACK_TIMEOUT(20),
      .BAT_TIMEOUT(60),
      .MAX_RETRY  (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .rx_data     (rx_data),
      .rx_done_tick(rx_done_tick),
      .tx_done_tick(tx_done_tick),
      .wr_ps2      (wr_ps2),
      .tx_data     (tx_data),
      .busy        (busy),
      .init_done   (init_done),
      .init_error  (init_error),
      .retry_cnt   (retry_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every transmit request must match the oldest queued byte
   always @(negedge clk) begin
      if (!rst && wr_ps2) begin
         check_eq("tx_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
   end

   // All drivers are called on a falling edge and return on a later falling edge
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_txd();
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic wait_wr();
      int n = 0;
      while (!wr_ps2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("wr_seen", 32'(wr_ps2), 32'd1);
      @(negedge clk);
   endtask

   // Reset command: ACK, BAT OK, ID; Set Rate follows two cycles after the ID
   task automatic reset_step();
      wait_wr();
      pulse_txd();
      pulse_rx(8'hFA);
      pulse_rx(8'hAA);
      exp_q.push_back(exp_cmd[1]);
      pulse_rx(8'h00);
      check_eq("id_next_wait", 32'(wr_ps2), 32'd0);
      @(negedge clk);
      check_eq("id_next_send", 32'(wr_ps2), 32'd1);
   endtask

   task automatic ack_step(input int i);
      wait_wr();
      pulse_txd();
      if (i < 5) exp_q.push_back(exp_cmd[i+1]);
      pulse_rx(8'hFA);
      check_eq("ack_next_wait", 32'(wr_ps2), 32'd0);
      @(negedge clk);
      if (i < 5) check_eq("ack_next_send", 32'(wr_ps2), 32'd1);
      else       check_eq("done_latency", 32'(init_done), 32'd1);
   endtask

   task automatic run_nominal();
      exp_q.push_back(exp_cmd[0]);
      pulse_start();
      check_eq("start_wr", 32'(wr_ps2), 32'd1);
      check_eq("start_busy", 32'(busy), 32'd1);
      reset_step();
      for (int i = 1; i <= 5; i++) ack_step(i);
      check_eq("nom_done", 32'(init_done), 32'd1);
      check_eq("nom_busy", 32'(busy), 32'd0);
      check_eq("nom_retry", 32'(retry_cnt), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_cmd      = '{8'hFF, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4};
      rst          = 1'b1;
      start        = 1'b0;
      rx_data      = 8'h00;
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_wr", 32'(wr_ps2), 32'd0);
      check_eq("rst_tx", 32'(tx_data), 32'h00);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(init_done), 32'd0);
      check_eq("rst_err", 32'(init_error), 32'd0);
      check_eq("rst_retry", 32'(retry_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Nominal bring-up, then stray ticks in DONE must change nothing
      run_nominal();
      pulse_txd();
      pulse_rx(8'hFA);
      check_eq("done_hold", 32'(init_done), 32'd1);

      // Resend on the first Set Rate
      exp_q.push_back(exp_cmd[0]);
      pulse_start();
      reset_step();
      wait_wr();
      pulse_txd();
      exp_q.push_back(exp_cmd[1]);
      pulse_rx(8'hFE);
      check_eq("resend_retry", 32'(retry_cnt), 32'd1);
      for (int i = 1; i <= 5; i++) ack_step(i);
      check_eq("resend_done", 32'(init_done), 32'd1);
      check_eq("resend_retry_end", 32'(retry_cnt), 32'd1);

      // Bad BAT four times in a row exhausts the retry budget
      exp_q.push_back(exp_cmd[0]);
      pulse_start();
      for (int j = 0; j < 4; j++) begin
         wait_wr();
         pulse_txd();
         pulse_rx(8'hFA);
         if (j < 3) exp_q.push_back(exp_cmd[0]);
         pulse_rx(8'hFC);
         if (j < 3) check_eq("bat_retry", 32'(retry_cnt), 32'(j + 1));
      end
      check_eq("bat_error", 32'(init_error), 32'd1);
      check_eq("bat_busy", 32'(busy), 32'd0);
      check_eq("bat_retry_end", 32'(retry_cnt), 32'd3);
      pulse_rx(8'hAA);
      check_eq("error_hold", 32'(init_error), 32'd1);

      // Restart from ERROR, then let the ACK to F4 time out
      exp_q.push_back(exp_cmd[0]);
      pulse_start();
      check_eq("err_clear", 32'(init_error), 32'd0);
      check_eq("err_retry_clear", 32'(retry_cnt), 32'd0);
      reset_step();
      for (int i = 1; i <= 4; i++) ack_step(i);
      wait_wr();
      pulse_txd();
      // First cycle in WAIT_ACK; the timer reads zero 20 cycles later, SEND follows
      exp_q.push_back(exp_cmd[0]);
      begin
         int early = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_ps2) early++;
         end
         check_eq("to_not_early", 32'(early), 32'd0);
      end
      @(negedge clk);
      check_eq("to_restart_wr", 32'(wr_ps2), 32'd1);
      check_eq("to_restart_tx", 32'(tx_data), 32'hFF);
      check_eq("to_retry", 32'(retry_cnt), 32'd1);

      // ACK lands on the exact expiry cycle of the Set Rate wait
      reset_step();
      wait_wr();
      pulse_txd();
      repeat (20) @(negedge clk);
      exp_q.push_back(exp_cmd[2]);
      pulse_rx(8'hFA);
      check_eq("coll_retry", 32'(retry_cnt), 32'd1);
      @(negedge clk);
      check_eq("coll_next_send", 32'(wr_ps2), 32'd1);
      for (int i = 2; i <= 5; i++) ack_step(i);
      check_eq("coll_done", 32'(init_done), 32'd1);
      check_eq("coll_retry_end", 32'(retry_cnt), 32'd1);

      // Reset while waiting for BAT, then a clean nominal run
      exp_q.push_back(exp_cmd[0]);
      pulse_start();
      wait_wr();
      pulse_txd();
      pulse_rx(8'hFA);
      check_eq("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_wr", 32'(wr_ps2), 32'd0);
      check_eq("mid_rst_tx", 32'(tx_data), 32'h00);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_done", 32'(init_done), 32'd0);
      check_eq("mid_rst_err", 32'(init_error), 32'd0);
      check_eq("mid_rst_retry", 32'(retry_cnt), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("no_autostart", 32'(busy), 32'd0);
      run_nominal();

      repeat (3) @(negedge clk);
      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_mouse_init_sequencer.md
# ps2_mouse_init_sequencer

Sequences the full PS/2 mouse bring-up after power-on or on request: resets the mouse, sets sample rate and resolution, and enables stream-mode data reporting. Each command gets an acknowledge check, a timeout and bounded retries. Sits between the top-level mouse interface and the shared PS/2 rx/tx engine, and owns that engine's transmit side until initialisation completes. On completion, received bytes belong to the packet decoder.

## Interface
Parameters:
- SAMPLE_RATE, 8'd100: argument sent after 0xF3 (Set Sample Rate).
- RESOLUTION, 8'd2: argument sent after 0xE8 (Set Resolution).
- ACK_TIMEOUT, 100_000: cycles allowed for tx completion or for any single response byte except BAT.
- BAT_TIMEOUT, 50_000_000: cycles allowed for 0xAA after the reset ACK.
- MAX_RETRY, 3: retries allowed before declaring error; valid range 1..15.

Ports:
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or restart the sequence; sampled only in IDLE, DONE and ERROR.
- rx_data  in  8  byte from the PS/2 receiver.
- rx_done_tick  in  1  rx_data valid this cycle.
- tx_done_tick  in  1  transmitter finished the current byte.
- wr_ps2  out  1  one-cycle transmit request.
- tx_data  out  8  byte to transmit; registered; valid when wr_ps2 is high and held until the next request.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- init_done  out  1  level; high while in DONE.
- init_error  out  1  level; high while in ERROR.
- retry_cnt  out  4  retries consumed in the current run.

## Operation
Command list, indexed by step 0..5:
- Step 0: 0xFF (reset). Expect 0xFA, then 0xAA, then 0x00 (device ID).
- Step 1: 0xF3. Expect 0xFA.
- Step 2: SAMPLE_RATE. Expect 0xFA.
- Step 3: 0xE8. Expect 0xFA.
- Step 4: RESOLUTION. Expect 0xFA.
- Step 5: 0xF4 (enable reporting). Expect 0xFA.

States:
- IDLE: on start, set step=0 and retry_cnt=0, then go to SEND.
- SEND: wr_ps2=1 for one cycle with tx_data=cmd[step]; load timer with ACK_TIMEOUT; go to WAIT_TX.
- WAIT_TX: on tx_done_tick, reload timer with ACK_TIMEOUT and go to WAIT_ACK. rx_done_tick is ignored in this state.
- WAIT_ACK: on rx_done_tick:
  - 0xFA: step 0 goes to WAIT_BAT with timer=BAT_TIMEOUT; any other step goes to NEXT.
  - 0xFE (resend): retry the same step.
  - Any other byte: restart from step 0.
- WAIT_BAT: 0xAA goes to WAIT_ID with timer=ACK_TIMEOUT. Any other byte restarts from step 0.
- WAIT_ID: 0x00 goes to NEXT. Any other byte restarts from step 0.
- NEXT: if step==5, go to DONE; otherwise step+1 and go to SEND.
- DONE: hold. Ignore all rx and tx ticks. start restarts the full sequence.
- ERROR: hold. Ignore ticks. start clears init_error and restarts with retry_cnt=0.

Retry rules:
- Retry (same step) and restart (step 0) each increment retry_cnt.
- If retry_cnt already equals MAX_RETRY, go to ERROR instead of retrying or restarting.
- Timer expiry in any wait state counts as a restart.

## Timing
- Reset values: state=IDLE, step=0, wr_ps2=0, tx_data=8'h00, busy=0, init_done=0, init_error=0, retry_cnt=0.
- start high in IDLE at cycle n: SEND at n+1, with wr_ps2=1 and tx_data=0xFF in cycle n+1.
- tx_done_tick at cycle m in WAIT_TX: the state accepts rx from m+1.
- Response accepted at cycle k: the next command's wr_ps2 fires at k+2 (via NEXT, then SEND).
- Final 0xFA accepted at cycle k: init_done rises at k+2 (via NEXT) and stays high.
- Timer:
  - Decrements once per cycle in the wait states and expires when it reaches 0.
  - Width is $clog2(max(ACK_TIMEOUT, BAT_TIMEOUT)+1).
  - If rx_done_tick or tx_done_tick arrives in the same cycle as expiry, the tick wins.
- rst mid-sequence: IDLE in the next cycle with all outputs at reset values. Any in-flight transmission is abandoned. There is no automatic restart.
- start while busy: ignored.

## Structure
- Package ps2_mouse_pkg holds:
  - command and response constants: CMD_RESET 0xFF, CMD_SET_RATE 0xF3, CMD_SET_RES 0xE8, CMD_ENABLE 0xF4, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_BAT_OK 0xAA, RSP_ID 0x00;
  - the state encoding localparams.
- Sub-module ps2_watchdog_timer: loadable down-counter with parameterised width; inputs load, load_val, en; output expired.
- Command selection is a combinational case on step inside the sequencer.

## Test plan
- Nominal: start; the model answers FA, AA, 00, then FA ×5. Required: tx bytes FF, F3, 64, E8, 02, F4 in order; init_done=1; retry_cnt=0.
- Resend: reply FE to the first F3, then FA. Required: F3 is transmitted again, retry_cnt=1, init_done=1.
- Bad BAT: reply FC instead of AA. Required: the sequence restarts with FF and retry_cnt=1. After three further FC replies: init_error=1, busy=0, retry_cnt=3.
- Timeout (ACK_TIMEOUT=20): no reply after F4. Required: restart 20 cycles after entering WAIT_ACK; tx_data=0xFF.
- Collision: rx_done_tick with FA in the same cycle the timer expires. Required: FA is accepted, no restart.
- Reset mid-run: assert rst during WAIT_BAT. Required: all outputs at reset values next cycle; a fresh start then completes the nominal sequence.
